// File: rtl/uart_receiver_if.sv
// -----------------------------------------------------------------------------
// uart_receiver_if
// Byte-side port of the UART receiver. It carries the received byte, the
// valid/ready handshake and the two error pulses.
//   data_out        [7:0] received byte, stable while data_out_valid is high
//   data_out_valid        data_out holds an unconsumed byte
//   data_out_ready        consumer accepts the byte on a valid & ready edge
//   framing_error         one-cycle pulse: the stop bit was sampled as 0
//   overrun               one-cycle pulse: a byte was dropped because the
//                         holding register was full
// The receiver connects to the master modport and the consumer to the slave
// modport.
// -----------------------------------------------------------------------------
interface uart_receiver_if;
    logic [7:0] data_out;
    logic       data_out_valid;
    logic       data_out_ready;
    logic       framing_error;
    logic       overrun;

    modport master (
        output data_out,
        output data_out_valid,
        output framing_error,
        output overrun,
        input  data_out_ready
    );

    modport slave (
        input  data_out,
        input  data_out_valid,
        input  framing_error,
        input  overrun,
        output data_out_ready
    );
endinterface

// File: rtl/uart_receiver.sv
// -----------------------------------------------------------------------------
// uart_receiver
// Receive half of the 8N1 UART link: start bit 0, 8 data bits LSB first,
// stop bit 1. The asynchronous RX line is synchronised and then sampled in
// the middle of each bit. A complete byte goes into a one-entry holding
// register that is read through a valid/ready handshake. Framing errors and
// overruns are reported as one-cycle pulses.
//   clk        clock
//   reset      synchronous, active-high reset
//   serial_in  asynchronous RX line, idle high
//   rx_if      byte handshake and error pulses (master side)
// -----------------------------------------------------------------------------
module uart_receiver #(
    parameter int CLOCK_FREQ = 125_000_000,
    parameter int BAUD_RATE  = 115_200
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              serial_in,
    uart_receiver_if.master   rx_if
);

    localparam int SYMBOL_EDGE_TIME = CLOCK_FREQ / BAUD_RATE;
    localparam int SAMPLE_TIME      = SYMBOL_EDGE_TIME / 2;
    localparam int CNT_W            = $clog2(SYMBOL_EDGE_TIME);

    localparam logic [CNT_W-1:0] SAMPLE_LAST = CNT_W'(SAMPLE_TIME - 1);
    localparam logic [CNT_W-1:0] SYMBOL_LAST = CNT_W'(SYMBOL_EDGE_TIME - 1);
    localparam logic [CNT_W-1:0] CNT_ONE     = CNT_W'(1);

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        START     = 3'd1,
        DATA      = 3'd2,
        STOP      = 3'd3,
        WAIT_HIGH = 3'd4
    } state_t;

    state_t           state_q;
    logic [1:0]       sync_q;
    logic             rx_s;
    logic [CNT_W-1:0] cnt_q;
    logic [2:0]       bit_idx_q;
    logic [7:0]       shift_q;
    logic [7:0]       data_q;
    logic             valid_q;
    logic             fe_q;
    logic             ov_q;

    // The second synchroniser flop is the only view of the line the FSM uses.
    assign rx_s = sync_q[1];

    assign rx_if.data_out       = data_q;
    assign rx_if.data_out_valid = valid_q;
    assign rx_if.framing_error  = fe_q;
    assign rx_if.overrun        = ov_q;

    // Synchroniser, receive FSM, holding register and error pulses.
    always_ff @(posedge clk) begin
        if (reset) begin
            sync_q    <= 2'b11;
            state_q   <= IDLE;
            cnt_q     <= '0;
            bit_idx_q <= 3'd0;
            shift_q   <= 8'h00;
            data_q    <= 8'h00;
            valid_q   <= 1'b0;
            fe_q      <= 1'b0;
            ov_q      <= 1'b0;
        end else begin
            sync_q <= {sync_q[0], serial_in};
            fe_q   <= 1'b0;
            ov_q   <= 1'b0;

            // Consumption. A byte loaded at the stop sample below overrides this.
            if (valid_q && rx_if.data_out_ready) begin
                valid_q <= 1'b0;
            end

            case (state_q)
                IDLE: begin
                    if (!rx_s) begin
                        state_q <= START;
                        cnt_q   <= '0;
                    end
                end

                START: begin
                    if (cnt_q == SAMPLE_LAST) begin
                        cnt_q     <= '0;
                        bit_idx_q <= 3'd0;
                        // A line that has returned high by mid-start-bit was a glitch.
                        state_q   <= rx_s ? IDLE : DATA;
                    end else begin
                        cnt_q <= cnt_q + CNT_ONE;
                    end
                end

                DATA: begin
                    if (cnt_q == SYMBOL_LAST) begin
                        cnt_q   <= '0;
                        shift_q <= {rx_s, shift_q[7:1]};
                        if (bit_idx_q == 3'd7) begin
                            state_q <= STOP;
                        end else begin
                            bit_idx_q <= bit_idx_q + 3'd1;
                        end
                    end else begin
                        cnt_q <= cnt_q + CNT_ONE;
                    end
                end

                STOP: begin
                    if (cnt_q == SYMBOL_LAST) begin
                        cnt_q <= '0;
                        if (rx_s) begin
                            // The FSM returns to IDLE at mid-stop-bit, so a
                            // back-to-back start edge is still caught.
                            state_q <= IDLE;
                            if (!valid_q || rx_if.data_out_ready) begin
                                data_q  <= shift_q;
                                valid_q <= 1'b1;
                            end else begin
                                ov_q <= 1'b1;
                            end
                        end else begin
                            fe_q    <= 1'b1;
                            state_q <= WAIT_HIGH;
                        end
                    end else begin
                        cnt_q <= cnt_q + CNT_ONE;
                    end
                end

                WAIT_HIGH: begin
                    // A break holds the line low. Wait it out so that only one error is reported.
                    if (rx_s) begin
                        state_q <= IDLE;
                    end
                end

                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_receiver.sv
// -----------------------------------------------------------------------------
// tb_uart_receiver
// Self-checking bench for uart_receiver at 10 clk per bit. A table of frames
// drives the main cases. Hand-written sequences cover the glitch, overrun and
// mid-frame reset cases. Bytes expected on the handshake go into a queue, and
// each accepted byte is popped from it and compared.
// -----------------------------------------------------------------------------
module tb_uart_receiver;

    localparam int CF  = 1_000_000;
    localparam int BR  = 100_000;
    localparam int BIT = CF / BR;
    // 3 clk of synchroniser/IDLE delay + SAMPLE_TIME + 9 bits
    localparam int EXP_LATENCY = 3 + BIT / 2 + 9 * BIT;

    logic clk = 1'b0;
    logic reset;
    logic serial_in;

    always #5 clk = ~clk;

    uart_receiver_if rx_if ();

    uart_receiver #(
        .CLOCK_FREQ (CF),
        .BAUD_RATE  (BR)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .serial_in (serial_in),
        .rx_if     (rx_if)
    );

    int         n_checks    = 0;
    int         n_errors    = 0;
    int         cyc         = 0;
    int         valid_rises = 0;
    int         fe_pulses   = 0;
    int         ov_pulses   = 0;
    int         rise_cyc    = 0;
    int         fall_cyc    = 0;
    logic [7:0] sb_q[$];

    typedef struct {
        logic [7:0] data;
        logic       stop_b;
        int         idle_low;
        int         idle_high;
        int         exp_valid;
        int         exp_fe;
    } vec_t;

    vec_t vecs[6];

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h) at cycle %0d",
                     name, act, act, exp, exp, cyc);
        end
    endtask

    // Advance n clocks and land just after the active edge.
    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send_frame(input logic [7:0] d, input logic stop_b);
        fall_cyc  = cyc;
        serial_in = 1'b0;
        tick(BIT);
        for (int i = 0; i < 8; i++) begin
            serial_in = d[i];
            tick(BIT);
        end
        serial_in = stop_b;
        tick(BIT);
    endtask

    initial forever @(posedge clk) cyc <= cyc + 1;

    // Monitor: counts pulses and checks each accepted byte against the queue.
    initial begin
        logic       prev_valid;
        logic [7:0] exp_b;
        prev_valid = 1'b0;
        forever begin
            @(negedge clk);
            if (rx_if.data_out_valid === 1'b1 && prev_valid !== 1'b1) begin
                valid_rises++;
                rise_cyc = cyc;
            end
            prev_valid = rx_if.data_out_valid;
            if (rx_if.framing_error === 1'b1) fe_pulses++;
            if (rx_if.overrun === 1'b1) ov_pulses++;
            if (rx_if.data_out_valid === 1'b1 && rx_if.data_out_ready === 1'b1) begin
                if (sb_q.size() == 0) begin
                    n_checks++;
                    n_errors++;
                    $display("FAIL sb_extra: got byte 0x%02h, expected no byte at cycle %0d",
                             rx_if.data_out, cyc);
                end else begin
                    exp_b = sb_q.pop_front();
                    chk("sb_data", int'(rx_if.data_out), int'(exp_b));
                end
            end
        end
    end

    initial begin
        int v0, f0, o0;

        vecs[0] = '{data: 8'hA5, stop_b: 1'b1, idle_low: 0,  idle_high: 20, exp_valid: 1, exp_fe: 0};
        vecs[1] = '{data: 8'h00, stop_b: 1'b1, idle_low: 0,  idle_high: 0,  exp_valid: 1, exp_fe: 0};
        vecs[2] = '{data: 8'hFF, stop_b: 1'b1, idle_low: 0,  idle_high: 0,  exp_valid: 1, exp_fe: 0};
        vecs[3] = '{data: 8'h5A, stop_b: 1'b1, idle_low: 0,  idle_high: 20, exp_valid: 1, exp_fe: 0};
        vecs[4] = '{data: 8'h3C, stop_b: 1'b0, idle_low: 30, idle_high: 20, exp_valid: 0, exp_fe: 1};
        vecs[5] = '{data: 8'hC3, stop_b: 1'b1, idle_low: 0,  idle_high: 20, exp_valid: 1, exp_fe: 0};

        // Reset state
        reset                = 1'b1;
        serial_in            = 1'b1;
        rx_if.data_out_ready = 1'b1;
        tick(3);
        chk("rst_valid", int'(rx_if.data_out_valid), 0);
        chk("rst_data",  int'(rx_if.data_out), 0);
        chk("rst_fe",    int'(rx_if.framing_error), 0);
        chk("rst_ov",    int'(rx_if.overrun), 0);
        reset = 1'b0;
        tick(5);

        // Table-driven frames: single, back-to-back, framing error, recovery.
        for (int i = 0; i < 6; i++) begin
            v0 = valid_rises;
            f0 = fe_pulses;
            o0 = ov_pulses;
            if (vecs[i].exp_valid != 0) sb_q.push_back(vecs[i].data);
            send_frame(vecs[i].data, vecs[i].stop_b);
            if (vecs[i].exp_valid != 0) chk("latency", rise_cyc - fall_cyc, EXP_LATENCY);
            if (vecs[i].idle_low > 0) begin
                serial_in = 1'b0;
                tick(vecs[i].idle_low);
            end
            serial_in = 1'b1;
            tick(vecs[i].idle_high);
            chk("vec_valid_pulses", valid_rises - v0, vecs[i].exp_valid);
            chk("vec_fe_pulses",    fe_pulses - f0,   vecs[i].exp_fe);
            chk("vec_ov_pulses",    ov_pulses - o0,   0);
        end

        // Glitch: 3 clk low on an idle line.
        v0 = valid_rises;
        f0 = fe_pulses;
        serial_in = 1'b0;
        tick(3);
        serial_in = 1'b1;
        tick(20);
        chk("glitch_valid", valid_rises - v0, 0);
        chk("glitch_fe",    fe_pulses - f0,   0);

        // Overrun: ready low, two frames; the first is held and the second is dropped.
        v0 = valid_rises;
        o0 = ov_pulses;
        rx_if.data_out_ready = 1'b0;
        send_frame(8'h11, 1'b1);
        tick(20);
        send_frame(8'h22, 1'b1);
        tick(20);
        chk("ovr_valid_pulses", valid_rises - v0, 1);
        chk("ovr_pulses",       ovr_delta(o0), 1);
        chk("ovr_valid_held",   int'(rx_if.data_out_valid), 1);
        chk("ovr_data_held",    int'(rx_if.data_out), 'h11);
        sb_q.push_back(8'h11);
        rx_if.data_out_ready = 1'b1;
        tick(2);
        chk("ovr_valid_fall", int'(rx_if.data_out_valid), 0);
        chk("ovr_consumed",   sb_q.size(), 0);

        // Reset during data bit 4 of 8'h77, then a clean 8'h81.
        v0 = valid_rises;
        serial_in = 1'b0;
        tick(BIT);
        for (int i = 0; i < 4; i++) begin
            serial_in = ((8'h77 >> i) & 8'h01) != 8'h00;
            tick(BIT);
        end
        serial_in = 1'b1;
        tick(BIT / 2);
        reset = 1'b1;
        tick(1);
        chk("midrst_valid", int'(rx_if.data_out_valid), 0);
        chk("midrst_data",  int'(rx_if.data_out), 0);
        chk("midrst_fe",    int'(rx_if.framing_error), 0);
        chk("midrst_ov",    int'(rx_if.overrun), 0);
        tick(2);
        reset = 1'b0;
        tick(20);
        sb_q.push_back(8'h81);
        send_frame(8'h81, 1'b1);
        tick(20);
        chk("midrst_valid_pulses", valid_rises - v0, 1);

        chk("sb_drained", sb_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    function automatic int ovr_delta(input int base);
        return ov_pulses - base;
    endfunction

endmodule

// File: doc/uart_receiver.md
Name: uart_receiver

Overview:
- Receive half of the UART link, paired with the existing transmitter. Same 8N1 framing: start bit 0, 8 data bits LSB first, stop bit 1.
- Converts asynchronous serial_in into bytes on a valid/ready output port, with mid-bit sampling.
- Flags framing errors and overruns. Sits between the board RX pin and the core's MMIO/UART controller.

Parameters:
- CLOCK_FREQ, 125_000_000, clk frequency in Hz.
- BAUD_RATE, 115_200, line rate in bits/s.
- Derived localparam SYMBOL_EDGE_TIME = CLOCK_FREQ / BAUD_RATE (integer division).
- Derived localparam SAMPLE_TIME = SYMBOL_EDGE_TIME / 2.
- Counter width is $clog2(SYMBOL_EDGE_TIME).

Ports:
- clk  input  1  clock.
- reset  input  1  synchronous, active-high reset; clock clk.
- serial_in  input  1  asynchronous RX line, idle high.
- data_out  output  8  received byte.
- data_out_valid  output  1  data_out holds an unconsumed byte.
- data_out_ready  input  1  consumer accepts the byte when valid & ready at a clk edge.
- framing_error  output  1  one-cycle pulse: stop bit sampled 0.
- overrun  output  1  one-cycle pulse: a byte completed while the holding register was full and not being consumed.

Behaviour:
- Synchronizer:
  - 2-flop synchronizer on serial_in; both flops reset to 1.
  - All FSM decisions use the second flop, rx_s.
- Reset values: state IDLE, counters 0, data_out 8'h00, data_out_valid 0, framing_error 0, overrun 0.
- Reset mid-frame aborts the frame; any held byte is discarded.
- FSM states: IDLE, START, DATA, STOP, WAIT_HIGH.
  - IDLE: at the edge where rx_s==0, go to START with clock counter cleared. Call this edge E.
  - START: counter counts each cycle.
    - When counter==SAMPLE_TIME-1 (edge E+SAMPLE_TIME), sample rx_s.
    - If 0: go to DATA, clear counter and bit index.
    - If 1: false start (glitch), return to IDLE with no outputs.
  - DATA: sample rx_s when counter==SYMBOL_EDGE_TIME-1, then clear counter.
    - Bit k (k=0..7) is sampled at edge E+SAMPLE_TIME+(k+1)*SYMBOL_EDGE_TIME.
    - Shift right into the shift register, MSB in, so bit 0 ends in the LSB.
    - After bit 7, go to STOP.
  - STOP: sample at E+SAMPLE_TIME+9*SYMBOL_EDGE_TIME.
    - rx_s==1: frame good, deliver per the output rules, go to IDLE.
    - rx_s==0: framing_error pulses high for exactly the next cycle, byte discarded, go to WAIT_HIGH.
  - WAIT_HIGH: stay until rx_s==1, then go to IDLE. A break condition therefore produces exactly one framing_error.
- Output holding register, evaluated at the good-stop edge:
  - data_out_valid==0, or data_out_valid & data_out_ready in the same cycle: load data_out with the new byte; data_out_valid is 1 from the next cycle.
  - data_out_valid & !data_out_ready: keep the old byte, drop the new one, overrun pulses for one cycle.
  - Otherwise valid & ready clears data_out_valid next cycle. data_out is stable while valid is high.
- Latency: data_out_valid rises the cycle after edge E+SAMPLE_TIME+9*SYMBOL_EDGE_TIME. Edge E is 2–3 clks after the serial_in fall, due to the synchronizer.
- Back-to-back frames:
  - Receiver is back in IDLE at mid-stop-bit, so the next start edge, one half-bit later, is caught.
  - Reception continues regardless of data_out_ready.
- Arithmetic:
  - Counters wrap only through explicit clears; never compare with a width-mismatched constant.
  - SYMBOL_EDGE_TIME >= 4 required.

Test Plan:
- CLOCK_FREQ=1_000_000, BAUD_RATE=100_000 (10 clk/bit, sample at 5), data_out_ready=1:
  - Send 8'hA5 -> data_out=8'hA5, data_out_valid high one cycle, no error pulses.
  - Valid rises the cycle after E+95.
- Back-to-back 8'h00, 8'hFF, 8'h5A with minimum idle (stop bit only), ready=1 -> three valid pulses in order with exact bytes.
- ready=0, send 8'h11 then 8'h22:
  - 8'h11 held on data_out with valid=1; one overrun pulse at the 8'h22 stop sample.
  - Raise ready -> 8'h11 consumed, valid falls.
- Send 8'h3C with stop bit forced 0, then hold the line low 30 clk, then release:
  - exactly one framing_error pulse, no valid.
  - next frame 8'hC3 received correctly.
- 3-clk low glitch on idle line -> START samples 1, returns to IDLE, no valid/error.
- Assert reset during data bit 4 of 8'h77, release, send 8'h81:
  - outputs at reset values during reset; only 8'h81 delivered.
